// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side drain engine
// (fifo_stream_reader and its two-entry output buffer).
package fifo_rd_pkg;

   localparam int BUF_DEPTH = 2;

   typedef logic [1:0] occ_t;

   typedef enum logic [1:0] {
      BUF_HOLD,
      BUF_PUSH,
      BUF_POP,
      BUF_SWAP
   } buf_op_e;

   // Only combinational (0) and single-cycle registered (1) FIFO reads exist.
   function automatic bit rd_latency_legal(input int lat);
      return (lat == 0) || (lat == 1);
   endfunction

   function automatic buf_op_e buf_op(input logic push, input logic pop);
      buf_op_e op;
      op = BUF_HOLD;
      if (push && pop) op = BUF_SWAP;
      else if (push)   op = BUF_PUSH;
      else if (pop)    op = BUF_POP;
      return op;
   endfunction

   // Words buffered plus words in flight, after this cycle's pop, must leave
   // a free slot; otherwise the read would have nowhere to land.
   function automatic logic credit_ok(input occ_t occ, input logic inflight,
                                      input logic pop);
      logic [2:0] committed;
      committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      return committed < 3'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream of fifo_stream_reader.
// master = the reader block, slave = the FIFO/downstream side.
interface fifo_stream_reader_if #(
   parameter int DATA_SIZE = 8
);

   logic                 fifo_empty;
   logic                 fifo_re;
   logic [DATA_SIZE-1:0] fifo_rddata;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_SIZE-1:0] out_data;

   modport master (
      input  fifo_empty,
      input  fifo_rddata,
      input  out_ready,
      output fifo_re,
      output out_valid,
      output out_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rddata,
      output out_ready,
      input  fifo_re,
      input  out_valid,
      input  out_data
   );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry FIFO-ordered output buffer. The head lives in its own register
// so the output word comes straight from a flop.
module fifo_rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DATA_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [DATA_SIZE-1:0] push_data,
   input  logic                 pop,
   output logic [DATA_SIZE-1:0] head_data,
   output occ_t                 occ
);

   logic [DATA_SIZE-1:0] head_q;
   logic [DATA_SIZE-1:0] tail_q;
   occ_t                 occ_q;
   buf_op_e              op;

   always_comb begin
      op = buf_op(push, pop);
   end

   // On a simultaneous push and pop the new word goes to the head only when
   // it is the sole survivor; otherwise the tail moves up behind the pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         unique case (op)
            BUF_PUSH: begin
               if (occ_q == 2'd0) head_q <= push_data;
               else               tail_q <= push_data;
               occ_q <= occ_q + 2'd1;
            end
            BUF_POP: begin
               head_q <= tail_q;
               occ_q  <= occ_q - 2'd1;
            end
            BUF_SWAP: begin
               if (occ_q == 2'd1) begin
                  head_q <= push_data;
               end else begin
                  head_q <= tail_q;
                  tail_q <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_data = head_q;
   assign occ       = occ_q;

   no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      !(push && (occ_q == 2'(BUF_DEPTH))));

   no_pop_when_empty : assert property (@(posedge clk) disable iff (rst)
      !(pop && (occ_q == 2'd0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: credit-based FIFO reads into a 2-entry buffer that
// feeds a valid/ready stream. FIFO_RD_COUNT_EN adds the rd_count pop counter.
module fifo_stream_reader
   import fifo_rd_pkg::*;
#(
   parameter int DATA_SIZE  = 8,
   parameter int RD_LATENCY = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_stream_reader_if.master bus
`ifdef FIFO_RD_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0] rd_count
`endif
);

   if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
      $error("fifo_stream_reader: RD_LATENCY must be 0 or 1");
   end

   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("fifo_stream_reader: CNT_WIDTH must be at least 1");
   end

   logic                 pop;
   logic                 push;
   logic                 inflight;
   logic [DATA_SIZE-1:0] head_data;
   occ_t                 occ;

   assign pop = bus.out_valid & bus.out_ready;

   // Combinational from out_ready and fifo_empty on purpose: a pop this cycle
   // frees a slot immediately, which is what keeps throughput at one word/cycle.
   assign bus.fifo_re = ~rst & ~bus.fifo_empty & credit_ok(occ, inflight, pop);

   if (RD_LATENCY == 0) begin : g_lat0
      assign inflight = 1'b0;
      assign push     = bus.fifo_re;
   end else begin : g_lat1
      logic inflight_q;

      always_ff @(posedge clk) begin
         if (rst) inflight_q <= 1'b0;
         else     inflight_q <= bus.fifo_re;
      end

      assign inflight = inflight_q;
      assign push     = inflight_q;
   end

   fifo_rd_skid_buf #(
      .DATA_SIZE (DATA_SIZE)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.fifo_rddata),
      .pop       (pop),
      .head_data (head_data),
      .occ       (occ)
   );

   assign bus.out_valid = (occ != 2'd0);
   assign bus.out_data  = head_data;

`ifdef FIFO_RD_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)      rd_count <= '0;
      else if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
   end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader (RD_LATENCY=1, CNT_WIDTH=4): a queue-based FIFO
// model feeds the DUT and a scoreboard checks every accepted word.
module tb_fifo_stream_reader;

   localparam int DW = 8;
   localparam int CW = 4;

   typedef struct {
      string      name;
      logic       ready;
      int         n_words;
      logic [7:0] base;
      int         cycles;
      int         exp_re;
      int         exp_pops;
      logic       exp_valid;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fifo_stream_reader_if #(.DATA_SIZE(DW)) bus ();

`ifdef FIFO_RD_COUNT_EN
   logic [CW-1:0] rd_count;
`endif

   fifo_stream_reader #(
      .DATA_SIZE  (DW),
      .RD_LATENCY (1),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef FIFO_RD_COUNT_EN
      ,
      .rd_count (rd_count)
`endif
   );

   always #5 clk = ~clk;

   int         n_checks;
   int         n_fail;
   int         pop_cnt;
   int         re_cnt;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   logic       s_re;
   logic       s_valid;
   logic [7:0] s_data;
   logic       prev_stall;
   logic [7:0] prev_data;
   vec_t       vecs[6];

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock cycle: sample at the falling edge, then advance the FIFO model
   // just after the rising edge so read data appears one cycle after fifo_re.
   task automatic tick();
      logic [7:0] word;
      @(negedge clk);
      s_re    = bus.fifo_re;
      s_valid = bus.out_valid;
      s_data  = bus.out_data;
      if (s_re) re_cnt++;
      checkOutput("re_while_empty", {31'b0, s_re & bus.fifo_empty}, 32'd0);
      if (prev_stall) begin
         checkOutput("hold_valid", {31'b0, s_valid}, 32'd1);
         checkOutput("hold_data", {24'b0, s_data}, {24'b0, prev_data});
      end
      if (s_valid && bus.out_ready && !rst) begin
         pop_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL extra_word: got 0x%0h, expected no word", s_data);
         end else begin
            word = exp_q.pop_front();
            checkOutput("word_order", {24'b0, s_data}, {24'b0, word});
         end
      end
      prev_stall = s_valid & ~bus.out_ready & ~rst;
      prev_data  = s_data;
      @(posedge clk);
      #1;
      if (s_re && !rst && fifo_q.size() > 0) bus.fifo_rddata = fifo_q.pop_front();
      bus.fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic doReset(input int cycles, input int n_words, input logic [7:0] base);
      rst = 1'b1;
      bus.out_ready = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      prev_stall = 1'b0;
      bus.fifo_rddata = '0;
      for (int i = 0; i < n_words; i++) begin
         fifo_q.push_back(8'(base + i));
         exp_q.push_back(8'(base + i));
      end
      bus.fifo_empty = (n_words == 0);
      for (int c = 0; c < cycles; c++) begin
         tick();
         checkOutput("rst_re", {31'b0, s_re}, 32'd0);
         if (c > 0) begin
            checkOutput("rst_valid", {31'b0, s_valid}, 32'd0);
            checkOutput("rst_data", {24'b0, s_data}, 32'd0);
         end
      end
      rst = 1'b0;
      pop_cnt = 0;
      re_cnt = 0;
   endtask

   task automatic applyStimulus(input vec_t v);
      doReset(2, v.n_words, v.base);
      bus.out_ready = v.ready;
      for (int c = 0; c < v.cycles; c++) tick();
      checkOutput({v.name, "_re"}, re_cnt, v.exp_re);
      checkOutput({v.name, "_pops"}, pop_cnt, v.exp_pops);
      checkOutput({v.name, "_valid"}, {31'b0, s_valid}, {31'b0, v.exp_valid});
      if (v.exp_valid) checkOutput({v.name, "_head"}, {24'b0, s_data}, {24'b0, v.base});
   endtask

   initial begin
      int   first_valid;
      int   last_valid;
      int   beats;
      logic pat[8];

      n_checks = 0;
      n_fail = 0;
      pop_cnt = 0;
      re_cnt = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      bus.out_ready = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_rddata = '0;

      //            name       rdy n   base   cyc re pops valid
      vecs[0] = '{"stall4",   1'b0, 4, 8'h11, 10, 2, 0, 1'b1};
      vecs[1] = '{"stream8",  1'b1, 8, 8'h21, 12, 8, 8, 1'b0};
      vecs[2] = '{"empty",    1'b1, 0, 8'h00,  5, 0, 0, 1'b0};
      vecs[3] = '{"stall1",   1'b0, 1, 8'h61,  6, 1, 0, 1'b1};
      vecs[4] = '{"stall2",   1'b0, 2, 8'h71,  6, 2, 0, 1'b1};
      vecs[5] = '{"stream3",  1'b1, 3, 8'h81,  8, 3, 3, 1'b0};

      for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

      // Reset release and gap-free streaming of 0x11..0x18
      doReset(2, 8, 8'h11);
      bus.out_ready = 1'b1;
      first_valid = -1;
      last_valid = -1;
      beats = 0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (c == 0) checkOutput("release_re", {31'b0, s_re}, 32'd1);
         if (s_valid) begin
            if (first_valid < 0) first_valid = c;
            last_valid = c;
            beats++;
         end
      end
      checkOutput("stream_first_valid", first_valid, 2);
      checkOutput("stream_span", last_valid - first_valid + 1, 8);
      checkOutput("stream_beats", beats, 8);
      checkOutput("stream_re", re_cnt, 8);
      checkOutput("stream_left", exp_q.size(), 0);

      // Backpressure for 10 cycles, then drain in order
      doReset(2, 4, 8'h11);
      for (int c = 0; c < 10; c++) tick();
      checkOutput("bp_re", re_cnt, 2);
      checkOutput("bp_head", {24'b0, s_data}, 32'h11);
      checkOutput("bp_valid", {31'b0, s_valid}, 32'd1);
      checkOutput("bp_fifo_left", fifo_q.size(), 2);
      bus.out_ready = 1'b1;
      re_cnt = 0;
      for (int c = 0; c < 8; c++) tick();
      checkOutput("bp_pops", pop_cnt, 4);
      checkOutput("bp_re_after", re_cnt, 2);
      checkOutput("bp_drained", {31'b0, s_valid}, 32'd0);
      checkOutput("bp_left", exp_q.size(), 0);

      // One word with the FIFO going empty while it is in flight
      doReset(2, 1, 8'hA5);
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int c = 0; c < 8; c++) begin
         bus.out_ready = pat[c];
         tick();
      end
      checkOutput("one_pops", pop_cnt, 1);
      checkOutput("one_valid_end", {31'b0, s_valid}, 32'd0);
      checkOutput("one_left", exp_q.size(), 0);

      // Reset with a full buffer
      doReset(2, 6, 8'h50);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      bus.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      checkOutput("full_valid", {31'b0, s_valid}, 32'd1);
      checkOutput("full_re", {31'b0, s_re}, 32'd0);
`ifdef FIFO_RD_COUNT_EN
      checkOutput("cnt_before_rst", {28'b0, rd_count}, 32'(pop_cnt));
`endif
      rst = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("midrst_valid", {31'b0, s_valid}, 32'd0);
`ifdef FIFO_RD_COUNT_EN
      checkOutput("midrst_cnt", {28'b0, rd_count}, 32'd0);
`endif

      // 17 pops wrap a 4-bit counter to 1
      doReset(2, 17, 8'h40);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 22; c++) tick();
      checkOutput("wrap_pops", pop_cnt, 17);
`ifdef FIFO_RD_COUNT_EN
      checkOutput("wrap_cnt", {28'b0, rd_count}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain engine for the team's synchronous FIFO. Monitors the FIFO's `empty` flag, issues read strobes, captures `rddata` after the configured memory read latency, and presents words on a valid/ready output stream. A 2-entry output buffer sustains one word per cycle under continuous `out_ready`, with no bubbles and no lost words under backpressure.

## Interface
- `DATA_SIZE`, 8, word width; must match the FIFO's `DATA_SIZE`.
- `RD_LATENCY`, 1, FIFO read latency in cycles.
  - 0: `fifo_rddata` is valid in the same cycle `fifo_re` is high.
  - 1: `fifo_rddata` is valid the cycle after `fifo_re` is high.
  - Other values are illegal (elaboration error).
- `CNT_WIDTH`, 16, width of the popped-word counter (used only with `FIFO_RD_COUNT_EN`).

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_re` out 1: FIFO read strobe.
- `fifo_rddata` in `DATA_SIZE`: FIFO read data.
- `out_valid` out 1: output word available.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out `DATA_SIZE`: output word.
- `rd_count` out `CNT_WIDTH`: count of words accepted downstream (present only with `FIFO_RD_COUNT_EN`).

## Operation
- State:
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: reads issued but not yet captured; 0..1, and always 0 when `RD_LATENCY`=0.
- `pop` = `out_valid & out_ready`.
- `fifo_re` = `~rst & ~fifo_empty & (occ + inflight - pop < 2)`.
  - This is combinational from `out_ready` and `fifo_empty`; that path is intentional.
  - `fifo_re` is never asserted while `fifo_empty` is high, so the block never underflows the FIFO.
- Capture:
  - `RD_LATENCY`=0: `fifo_rddata` is written into the buffer on the edge ending the `fifo_re` cycle.
  - `RD_LATENCY`=1: `inflight` is set by `fifo_re`, and `fifo_rddata` is captured on the following edge.
- Buffer behaviour:
  - The buffer is a FIFO-ordered 2-entry store.
  - `out_data` is the head entry.
  - `out_valid` = (`occ` != 0).
  - Push and pop may occur in the same cycle: `occ` is unchanged, the head advances, and the new word is enqueued behind it.
  - Push with `occ`=2 cannot occur because the credit rule forbids it; an assertion checks this.
- Stream rules:
  - `out_data` is stable while `out_valid & ~out_ready`.
  - `out_valid` never drops without a pop.
  - Word order equals FIFO order.
- Boundary conditions:
  - Empty FIFO: `fifo_re`=0; any buffered words still drain.
  - `out_ready` low for N cycles: the block reads at most 2 words ahead, then `fifo_re`=0 until a pop.
  - `fifo_empty` rising while a read is in flight: the in-flight word is still captured.
- Reset:
  - All state is cleared; `out_valid`=0, `out_data`=0, `fifo_re`=0, `rd_count`=0.
  - A word in flight at reset is discarded. For this reason `rst` must reset the FIFO and this block in the same cycle.

## Timing
- Latency from `fifo_empty` falling (with an empty buffer) to `out_valid` rising:
  - 1 cycle for `RD_LATENCY`=0.
  - 2 cycles for `RD_LATENCY`=1.
- Steady-state throughput is 1 word/cycle with `out_ready` held high and the FIFO non-empty, for both latencies.
- After `out_ready` rises following a stall: `pop` occurs that cycle, and `fifo_re` may assert in the same cycle.
- All outputs are registered except `fifo_re`.

## Configuration
- `FIFO_RD_COUNT_EN`:
  - Defined: `rd_count` port exists. It increments by 1 on every `pop`, wraps modulo 2^`CNT_WIDTH`, and is cleared by `rst`.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `fifo_rd_pkg`:
  - `localparam BUF_DEPTH = 2`.
  - `typedef logic [1:0] occ_t`.
  - The `RD_LATENCY` legality check function.
- Sub-module `fifo_rd_skid_buf`: 2-entry buffer with push/pop/`occ`, parameterised by `DATA_SIZE`.
- Top module: credit logic, in-flight tracking, optional counter.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `fifo_empty`=0. Required: `fifo_re`=0, `out_valid`=0, `out_data`=0 throughout; after release, `fifo_re`=1 on the first cycle.
- **Streaming:** `RD_LATENCY`=1, FIFO preloaded with 0x11..0x18, `out_ready`=1. Required: `out_valid` first rises 2 cycles after release, then 8 consecutive beats 0x11..0x18 with no gaps; `fifo_re` is high exactly 8 cycles.
- **Backpressure:** `out_ready`=0 for 10 cycles, FIFO holds 4 words. Required: exactly 2 `fifo_re` pulses, `out_data`=0x11 stable, `occ`=2; after `out_ready`=1, 0x11..0x14 arrive in order.
- **Empty mid-read:** `RD_LATENCY`=1, 1 word 0xA5, `out_ready` toggling 1,0,1. Required: 0xA5 delivered exactly once, then `out_valid`=0; `fifo_re` never high while `fifo_empty`=1.
- **Reset mid-stream:** assert `rst` with `occ`=2. Required: next cycle `out_valid`=0 and `rd_count`=0.
- **Counter wrap:** with `FIFO_RD_COUNT_EN` and `CNT_WIDTH`=4, pop 17 words. Required: `rd_count`=1.
